// File: rtl/mem_line_responder_if.sv
// Line request/response bundle between a cache (master) and the line responder (slave).
// Requests are level-held by the master until it sees the one-cycle mem_ready pulse.
interface mem_line_responder_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_line_responder.sv
// Fixed-latency line store that answers one cache-line read or write at a time.
//
//   state | meaning
//   IDLE  | waiting for exactly one of read/write; both at once flags proto_err
//   WAIT  | latency countdown on the captured request; initiator must hold it steady
//   READY | one-cycle mem_ready; writes commit and counters bump on the way out
module mem_line_responder #(
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 proc_reset_n,
  mem_line_responder_if.slave  mem,
  output logic                 busy,
  output logic                 proto_err,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int         DEPTH   = 2 ** DEPTH_LOG2;
  localparam logic [7:0] LAT_M1  = 8'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [7:0]        cnt_q;
  logic              ready_q;
  logic [LINE_W-1:0] rdata_q;
  logic              busy_q;
  logic              err_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;

  logic [LINE_W-1:0] line_mem [DEPTH];

  logic                  req_one;
  logic                  req_both;
  logic                  hold_ok;
  logic                  addr_ok;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] cap_idx;

  // Upper address bits alias onto the same lines; only the low bits index storage.
  assign req_idx  = mem.mem_addr[DEPTH_LOG2-1:0];
  assign cap_idx  = addr_q[DEPTH_LOG2-1:0];
  assign req_one  = mem.mem_read ^ mem.mem_write;
  assign req_both = mem.mem_read & mem.mem_write;
  assign hold_ok  = op_wr_q ? (mem.mem_write & ~mem.mem_read)
                            : (mem.mem_read & ~mem.mem_write);
  assign addr_ok  = (mem.mem_addr == addr_q);

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q  <= IDLE;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_both) begin
            err_q <= 1'b1;
          end else if (req_one) begin
            op_wr_q <= mem.mem_write;
            addr_q  <= mem.mem_addr;
            wdata_q <= mem.mem_wdata;
            cnt_q   <= LAT_M1;
            busy_q  <= 1'b1;
            if (LATENCY > 1) begin
              state_q <= WAIT;
            end else begin
              // Single-cycle latency skips WAIT, so the read data comes straight off the live address.
              state_q <= READY;
              ready_q <= 1'b1;
              if (!mem.mem_write) rdata_q <= line_mem[req_idx];
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 8'd1;
          if (!hold_ok || !addr_ok) err_q <= 1'b1;
          if (cnt_q == 8'd1) begin
            state_q <= READY;
            ready_q <= 1'b1;
            if (!op_wr_q) rdata_q <= line_mem[cap_idx];
          end
        end
        READY: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (op_wr_q) begin
            if (wr_cnt_q != CNT_MAX) wr_cnt_q <= wr_cnt_q + 1'b1;
          end else begin
            if (rd_cnt_q != CNT_MAX) rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; a reset forces IDLE, which also cancels a write still in READY.
  always_ff @(posedge clk) begin
    if (state_q == READY && op_wr_q) line_mem[cap_idx] <= wdata_q;
  end

  assign mem.mem_ready = ready_q;
  assign mem.mem_rdata = rdata_q;
  assign busy          = busy_q;
  assign proto_err     = err_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench: one responder at latency 8 / 16-bit counters, one at latency 1 / 8-bit counters.
module tb_mem_line_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n;
  logic        busy0, err0, busy1, err1;
  logic [15:0] rd0, wr0;
  logic [7:0]  rd1, wr1;

  mem_line_responder_if #(.ADDR_W(28), .LINE_W(128)) bus0 ();
  mem_line_responder_if #(.ADDR_W(28), .LINE_W(128)) bus1 ();

  mem_line_responder dut0 (
    .clk(clk), .proc_reset_n(rst0_n), .mem(bus0),
    .busy(busy0), .proto_err(err0), .rd_count(rd0), .wr_count(wr0)
  );

  mem_line_responder #(.LATENCY(1), .CNT_W(8)) dut1 (
    .clk(clk), .proc_reset_n(rst1_n), .mem(bus1),
    .busy(busy1), .proto_err(err1), .rd_count(rd1), .wr_count(wr1)
  );

  localparam logic [127:0] L1   = 128'hDEADBEEF_00000001_00000002_00000003;
  localparam logic [127:0] L9   = 128'h99999999_12345678_9ABCDEF0_00000009;
  localparam logic [127:0] L3   = 128'h33333333_CAFEF00D_0BADC0DE_00000003;
  localparam logic [127:0] LA   = 128'hAAAAAAAA_55555555_AAAAAAAA_0000000A;
  localparam logic [127:0] L2   = 128'h22222222_01020304_05060708_00000002;
  localparam logic [127:0] ONES = {128{1'b1}};

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int pulses;
  int cyc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input int which, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((which == 0) ? !bus0.mem_ready : !bus1.mem_ready) && n < maxc);
  endtask

  task automatic xact0(input bit wr, input logic [27:0] addr, input logic [127:0] data,
                       output int n);
    bus0.mem_read  = !wr;
    bus0.mem_write = wr;
    bus0.mem_addr  = addr;
    bus0.mem_wdata = data;
    wait_rdy(0, 40, n);
    bus0.mem_read  = 1'b0;
    bus0.mem_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; bus0.mem_addr = '0; bus0.mem_wdata = '0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    @(negedge clk);

    chk("rst_ready", bus0.mem_ready, 0);
    chk("rst_rdata", bus0.mem_rdata, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_err", err0, 0);
    chk("rst_rd", rd0, 0);
    chk("rst_wr", wr0, 0);

    // write line 0x5
    xact0(1'b1, 28'h5, L1, lat);
    chk("wr5_lat", lat, 8);
    chk("wr5_pulse_end", bus0.mem_ready, 0);
    chk("wr5_busy_end", busy0, 0);
    chk("wr5_wrcnt", wr0, 1);

    // read 0x5, then hold rdata through idle cycles
    xact0(1'b0, 28'h5, '0, lat);
    chk("rd5_lat", lat, 8);
    chk("rd5_data", bus0.mem_rdata, L1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd5_hold", bus0.mem_rdata, L1);
    end
    chk("rd5_rdcnt", rd0, 1);

    xact0(1'b1, 28'h9, L9, lat);
    chk("wr9_lat", lat, 8);

    // write 0x3 then read 0x9 presented in the write's ready cycle
    bus0.mem_write = 1'b1; bus0.mem_addr = 28'h3; bus0.mem_wdata = L3;
    wait_rdy(0, 40, lat);
    chk("evict_wr_lat", lat, 8);
    chk("evict_wr_busy", busy0, 1);
    bus0.mem_write = 1'b0; bus0.mem_read = 1'b1; bus0.mem_addr = 28'h9;
    wait_rdy(0, 40, lat);
    chk("evict_gap", lat, 9);
    pulses = 2;
    bus0.mem_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus0.mem_ready) pulses++;
    end
    chk("evict_pulses", pulses, 2);
    chk("evict_rdata", bus0.mem_rdata, L9);
    chk("evict_wrcnt", wr0, 3);
    chk("evict_rdcnt", rd0, 2);

    xact0(1'b0, 28'h105, '0, lat);
    chk("alias_rdata", bus0.mem_rdata, L1);
    xact0(1'b0, 28'h3, '0, lat);
    chk("raw3_rdata", bus0.mem_rdata, L3);
    xact0(1'b1, 28'hA, LA, lat);

    // address changes from 0x9 to 0xA mid-WAIT
    bus0.mem_read = 1'b1; bus0.mem_addr = 28'h9;
    @(negedge clk);
    @(negedge clk);
    chk("viol_err_before", err0, 0);
    bus0.mem_addr = 28'hA;
    @(negedge clk);
    chk("viol_err_set", err0, 1);
    wait_rdy(0, 40, lat);
    chk("viol_lat", lat + 3, 8);
    chk("viol_rdata", bus0.mem_rdata, L9);
    bus0.mem_read = 1'b0;
    @(negedge clk);
    chk("viol_err_sticky", err0, 1);
    chk("viol_rdcnt", rd0, 5);

    rst0_n = 1'b0;
    @(negedge clk);
    chk("rst2_err", err0, 0);
    rst0_n = 1'b1;
    @(negedge clk);

    // read and write together in IDLE
    bus0.mem_read = 1'b1; bus0.mem_write = 1'b1; bus0.mem_addr = 28'h5;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus0.mem_ready) pulses++;
    end
    chk("both_pulses", pulses, 0);
    chk("both_err", err0, 1);
    chk("both_busy", busy0, 0);
    bus0.mem_read = 1'b0; bus0.mem_write = 1'b0;
    @(negedge clk);

    xact0(1'b0, 28'h5, '0, lat);
    chk("rd5b_rdata", bus0.mem_rdata, L1);

    // reset in the middle of a write to 0x7
    bus0.mem_write = 1'b1; bus0.mem_addr = 28'h7; bus0.mem_wdata = ONES;
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", busy0, 1);
    rst0_n = 1'b0;
    #1;
    chk("midrst_ready", bus0.mem_ready, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_err", err0, 0);
    chk("midrst_rdata", bus0.mem_rdata, 0);
    chk("midrst_rdcnt", rd0, 0);
    @(negedge clk);
    rst0_n = 1'b1;
    wait_rdy(0, 40, lat);
    chk("midrst_relat", lat, 8);
    bus0.mem_write = 1'b0;
    @(negedge clk);
    chk("midrst_wrcnt", wr0, 1);
    xact0(1'b0, 28'h7, '0, lat);
    chk("rd7_rdata", bus0.mem_rdata, ONES);

    // latency-1 instance
    bus1.mem_write = 1'b1; bus1.mem_addr = 28'h2; bus1.mem_wdata = L2;
    wait_rdy(1, 10, lat);
    chk("l1_wr_lat", lat, 1);
    bus1.mem_write = 1'b0;
    @(negedge clk);
    chk("l1_wrcnt", wr1, 1);
    bus1.mem_read = 1'b1;
    wait_rdy(1, 10, lat);
    chk("l1_rd_lat", lat, 1);
    chk("l1_rdata", bus1.mem_rdata, L2);
    pulses = 1;
    cyc = 0;
    while (pulses < 300 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus1.mem_ready) pulses++;
    end
    bus1.mem_read = 1'b0;
    chk("l1_pulses", pulses, 300);
    chk("l1_b2b_cycles", cyc, 598);
    @(negedge clk);
    chk("l1_rd_sat", rd1, 255);
    chk("l1_ready_end", bus1.mem_ready, 0);
    chk("l1_err", err1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
